// File: rtl/dram_pkg.sv
// Shared definitions for the single-bank DRAM controller.
//   - FSM state encoding (legacy-compatible constants plus an enum over them)
//   - width helpers for address, byte-enable and duration counters
//   - parameter legality check used at elaboration
package dram_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_READ    = ST_READ,
    S_REFRESH = ST_REFRESH
  } state_e;

  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int be_w_f(input int data_w);
    return data_w / 8;
  endfunction

  // Bits needed to hold values 0..maxval.
  function automatic int cnt_w_f(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int read_lat, input int period,
                                   input int ref_cycles);
    return (data_w > 0) && (data_w % 8 == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (read_lat >= 1) && (ref_cycles >= 1) &&
           (period > read_lat + ref_cycles);
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   ack        : controller is entering REFRESH this cycle (clears pending)
//   pending    : a refresh is owed to the bank
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int PERIOD = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ack,
  output logic pending
);

  localparam int CW = cnt_w_f(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          wrap;

  always_comb begin
    wrap      = (cnt_q == CW'(PERIOD - 1));
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    pending_d = pending_q;
    if (ack)  pending_d = 1'b0;
    // A new request wins over a same-cycle ack so no refresh is ever lost.
    if (wrap) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM model/controller with valid/ready request port,
// byte-enabled writes, fixed-latency reads and periodic refresh stalls.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (ready depends only on registers)
//   req_we               : 1 = write, 0 = read
//   req_addr/wdata/be    : word address, write data, byte enables
//   rsp_valid            : one-cycle pulse with read data
//   rsp_rdata            : read data, held until the next response
//   busy_refresh         : bank is in a refresh cycle
module dram_bank_ctrl
  import dram_pkg::*;
#(
  parameter int DATA_W         = 72,
  parameter int DEPTH          = 4,
  parameter int READ_LAT       = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [addr_w_f(DEPTH)-1:0]    req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [be_w_f(DATA_W)-1:0]     req_be,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          busy_refresh
);

  localparam int BE_W   = be_w_f(DATA_W);
  localparam int MAXDUR = (READ_LAT > REFRESH_CYCLES) ? READ_LAT : REFRESH_CYCLES;
  localparam int DW     = cnt_w_f(MAXDUR - 1);
  localparam logic [DW-1:0] RD_LOAD = DW'(READ_LAT - 1);
  localparam logic [DW-1:0] RF_LOAD = DW'(REFRESH_CYCLES - 1);

  if (!params_ok(DATA_W, DEPTH, READ_LAT, REFRESH_PERIOD, REFRESH_CYCLES)) begin : g_param_check
    $error("dram_bank_ctrl: illegal parameter combination");
  end

  state_e               state_q, state_d;
  logic [DW-1:0]        dur_q, dur_d;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [DATA_W-1:0]    rd_buf_q, rd_buf_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic                 refresh_pending;
  logic                 refresh_ack;
  logic                 accept;
  logic                 wr_en;
  logic [DATA_W-1:0]    wr_word;

  dram_refresh_timer #(
    .PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .ack     (refresh_ack),
    .pending (refresh_pending)
  );

  assign req_ready = (state_q == S_IDLE) && !refresh_pending;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    dur_d       = dur_q;
    vld_d       = vld_q;
    rd_buf_d    = rd_buf_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    refresh_ack = 1'b0;
    wr_en       = 1'b0;

    wr_word = mem_q[req_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) wr_word[8*i +: 8] = req_wdata[8*i +: 8];
    end

    case (state_q)
      S_IDLE: begin
        if (refresh_pending) begin
          state_d     = S_REFRESH;
          dur_d       = RF_LOAD;
          refresh_ack = 1'b1;
        end else if (accept) begin
          if (req_we) begin
            if (|req_be) begin
              wr_en           = 1'b1;
              vld_d[req_addr] = 1'b1;
            end
          end else begin
            // Sample at the accept edge; never-written words read as zero
            // so the array itself needs no reset.
            state_d  = S_READ;
            dur_d    = RD_LOAD;
            rd_buf_d = vld_q[req_addr] ? mem_q[req_addr] : '0;
          end
        end
      end
      S_READ: begin
        if (dur_q == '0) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_buf_q;
        end else begin
          dur_d = dur_q - DW'(1);
        end
      end
      S_REFRESH: begin
        if (dur_q == '0) state_d = S_IDLE;
        else             dur_d   = dur_q - DW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_REFRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dur_q       <= '0;
      vld_q       <= '0;
      rd_buf_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      vld_q       <= vld_d;
      rd_buf_q    <= rd_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[req_addr] <= wr_word;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign busy_refresh = busy_q;

endmodule
